// File: rtl/chan_readout_sequencer.sv
// Per-event channel readout sequencer: pops one event, then walks the enabled channels
// lowest-first, handing each to the command manager under a per-channel timeout.
module chan_readout_sequencer #(
   parameter int unsigned TIMEOUT_CYCLES = 40000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [4:0]  chan_en,
   input  logic        evt_fifo_valid,
   input  logic [31:0] evt_fifo_data,
   output logic        evt_fifo_rd,
   output logic        rd_req,
   output logic [2:0]  rd_chan,
   output logic [4:0]  rd_trig_type,
   output logic [23:0] rd_trig_num,
   input  logic        rd_ack,
   input  logic        rd_done,
   output logic        readout_done,
   output logic [4:0]  timeout_mask,
   output logic [7:0]  timeout_count,
   output logic [15:0] event_count,
   output logic [2:0]  state
);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_SELECT    = 3'd1;
   localparam logic [2:0] ST_REQUEST   = 3'd2;
   localparam logic [2:0] ST_WAIT_DONE = 3'd3;
   localparam logic [2:0] ST_FINISH    = 3'd4;

   localparam logic [15:0] CNT_LOAD = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state_q, state_d;
   logic [4:0]  pending_q, pending_d;
   logic [4:0]  work_mask_q, work_mask_d;
   logic [15:0] cnt_q, cnt_d;
   logic        evt_fifo_rd_q, evt_fifo_rd_d;
   logic        rd_req_q, rd_req_d;
   logic [2:0]  rd_chan_q, rd_chan_d;
   logic [4:0]  trig_type_q, trig_type_d;
   logic [23:0] trig_num_q, trig_num_d;
   logic        readout_done_q, readout_done_d;
   logic [4:0]  timeout_mask_q, timeout_mask_d;
   logic [7:0]  timeout_count_q, timeout_count_d;
   logic [15:0] event_count_q, event_count_d;
   logic [2:0]  lowest_chan;
   logic        expire;

   // Descending scan so the last hit, i.e. the lowest pending channel, wins.
   always_comb begin
      lowest_chan = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (pending_q[i]) lowest_chan = 3'(i);
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
      state_d         = state_q;
      pending_d       = pending_q;
      work_mask_d     = work_mask_q;
      cnt_d           = cnt_q;
      evt_fifo_rd_d   = 1'b0;
      rd_req_d        = rd_req_q;
      rd_chan_d       = rd_chan_q;
      trig_type_d     = trig_type_q;
      trig_num_d      = trig_num_q;
      readout_done_d  = 1'b0;
      timeout_mask_d  = timeout_mask_q;
      timeout_count_d = timeout_count_q;
      event_count_d   = event_count_q;
      expire          = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (enable && evt_fifo_valid) begin
               trig_type_d   = evt_fifo_data[28:24];
               trig_num_d    = evt_fifo_data[23:0];
               pending_d     = chan_en;
               work_mask_d   = 5'd0;
               evt_fifo_rd_d = 1'b1;
               state_d       = ST_SELECT;
            end
         end
         ST_SELECT: begin
            if (pending_q == 5'd0) begin
               state_d = ST_FINISH;
            end else begin
               rd_chan_d = lowest_chan;
               rd_req_d  = 1'b1;
               cnt_d     = CNT_LOAD;
               state_d   = ST_REQUEST;
            end
         end
         ST_REQUEST: begin
            if (rd_ack) begin
               rd_req_d = 1'b0;
               cnt_d    = CNT_LOAD;
               state_d  = ST_WAIT_DONE;
            end else if (cnt_q == 16'd0) begin
               expire = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_WAIT_DONE: begin
            if (rd_done) begin
               pending_d[rd_chan_q] = 1'b0;
               state_d              = ST_SELECT;
            end else if (cnt_q == 16'd0) begin
               expire = 1'b1;
            end else begin
               cnt_d = cnt_q - 16'd1;
            end
         end
         ST_FINISH: begin
            readout_done_d = 1'b1;
            timeout_mask_d = work_mask_q;
            event_count_d  = event_count_q + 16'd1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // A dead channel is abandoned and recorded, and the walk moves on.
      if (expire) begin
         work_mask_d[rd_chan_q] = 1'b1;
         if (timeout_count_q != 8'hFF) timeout_count_d = timeout_count_q + 8'd1;
         pending_d[rd_chan_q] = 1'b0;
         rd_req_d             = 1'b0;
         state_d              = ST_SELECT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= ST_IDLE;
         pending_q       <= 5'd0;
         work_mask_q     <= 5'd0;
         cnt_q           <= 16'd0;
         evt_fifo_rd_q   <= 1'b0;
         rd_req_q        <= 1'b0;
         rd_chan_q       <= 3'd0;
         trig_type_q     <= 5'd0;
         trig_num_q      <= 24'd0;
         readout_done_q  <= 1'b0;
         timeout_mask_q  <= 5'd0;
         timeout_count_q <= 8'd0;
         event_count_q   <= 16'd0;
      end else begin
         // NOTE: non-blocking assignments so every register sees the pre-edge values of the others.
         state_q         <= state_d;
         pending_q       <= pending_d;
         work_mask_q     <= work_mask_d;
         cnt_q           <= cnt_d;
         evt_fifo_rd_q   <= evt_fifo_rd_d;
         rd_req_q        <= rd_req_d;
         rd_chan_q       <= rd_chan_d;
         trig_type_q     <= trig_type_d;
         trig_num_q      <= trig_num_d;
         readout_done_q  <= readout_done_d;
         timeout_mask_q  <= timeout_mask_d;
         timeout_count_q <= timeout_count_d;
         event_count_q   <= event_count_d;
      end
   end

   assign evt_fifo_rd   = evt_fifo_rd_q;
   assign rd_req        = rd_req_q;
   assign rd_chan       = rd_chan_q;
   assign rd_trig_type  = trig_type_q;
   assign rd_trig_num   = trig_num_q;
   assign readout_done  = readout_done_q;
   assign timeout_mask  = timeout_mask_q;
   assign timeout_count = timeout_count_q;
   assign event_count   = event_count_q;
   assign state         = state_q;

endmodule

// File: tb/tb_chan_readout_sequencer.sv
// Scoreboard bench for chan_readout_sequencer: FIFO and command-manager models drive the DUT,
// monitors pop expected requests / completions from queues filled by the directed stimulus.
`timescale 1ns/1ps
module tb_chan_readout_sequencer;

   localparam int unsigned T_CYC = 16;
   localparam logic [2:0] S_IDLE = 3'd0, S_REQUEST = 3'd2, S_WAIT_DONE = 3'd3;

   logic        clk, reset, enable;
   logic [4:0]  chan_en;
   logic        evt_fifo_valid;
   logic [31:0] evt_fifo_data;
   logic        evt_fifo_rd, rd_req, rd_ack, rd_done, readout_done;
   logic [2:0]  rd_chan, state;
   logic [4:0]  rd_trig_type, timeout_mask;
   logic [23:0] rd_trig_num;
   logic [7:0]  timeout_count;
   logic [15:0] event_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [31:0] fifo_q[$];
   logic [31:0] exp_req[$];
   logic [31:0] exp_done[$];
   int          rise_cyc[$];
   int          rd_pulses = 0, done_seen = 0, rise_cnt = 0;
   int          fifo_rd_cyc = 0, done_cyc = 0, last_done_in_cyc = 0;
   int          done_delay = 10;
   logic [4:0]  dead_mask = 5'd0;
   int          stray_req = 0;

   chan_readout_sequencer #(.TIMEOUT_CYCLES(T_CYC)) dut (
      .clk(clk), .reset(reset), .enable(enable), .chan_en(chan_en),
      .evt_fifo_valid(evt_fifo_valid), .evt_fifo_data(evt_fifo_data), .evt_fifo_rd(evt_fifo_rd),
      .rd_req(rd_req), .rd_chan(rd_chan), .rd_trig_type(rd_trig_type), .rd_trig_num(rd_trig_num),
      .rd_ack(rd_ack), .rd_done(rd_done), .readout_done(readout_done),
      .timeout_mask(timeout_mask), .timeout_count(timeout_count), .event_count(event_count),
      .state(state)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] req_word(input int ch, input logic [31:0] entry);
      return {3'(ch), entry[28:0]};
   endfunction

   function automatic logic [31:0] done_word(input logic [4:0] m, input logic [7:0] tc, input logic [15:0] ec);
      return {3'b000, m, tc, ec};
   endfunction

   task automatic wait_done_count(input int target, input int budget);
      int k = 0;
      while (done_seen < target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("readout_done_count", done_seen, target);
   endtask

   // FWFT FIFO model: the entry under an evt_fifo_rd pulse has already been consumed.
   initial begin
      evt_fifo_valid = 1'b0;
      evt_fifo_data  = 32'd0;
      forever begin
         @(negedge clk);
         if (evt_fifo_rd) begin
            rd_pulses++;
            fifo_rd_cyc = cyc;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
         end
         evt_fifo_valid = (fifo_q.size() > 0);
         evt_fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
      end
   end

   // Command manager model: immediate ack, rd_done done_delay cycles later unless the channel is dead.
   initial begin
      logic busy;
      int   wait_cnt;
      int   stray_ack;
      logic [2:0] cur_ch;
      busy = 1'b0; wait_cnt = 0; stray_ack = 0; cur_ch = 3'd0;
      rd_ack = 1'b0; rd_done = 1'b0;
      forever begin
         @(negedge clk);
         rd_ack  = 1'b0;
         rd_done = 1'b0;
         if (reset) begin
            busy = 1'b0;
         end else if (stray_req != stray_ack) begin
            rd_done = 1'b1;
            stray_ack++;
         end else if (!busy && rd_req && state == S_REQUEST) begin
            rd_ack   = 1'b1;
            busy     = 1'b1;
            cur_ch   = rd_chan;
            wait_cnt = done_delay - 1;
         end else if (busy) begin
            if (state != S_WAIT_DONE) begin
               busy = 1'b0;
            end else if (!dead_mask[cur_ch]) begin
               if (wait_cnt == 0) begin
                  rd_done = 1'b1;
                  busy = 1'b0;
                  last_done_in_cyc = cyc;
               end else begin
                  wait_cnt--;
               end
            end
         end
      end
   end

   // Request monitor.
   initial begin
      logic prev;
      logic [31:0] e;
      prev = 1'b0;
      forever begin
         @(negedge clk);
         if (rd_req && !prev) begin
            rise_cnt++;
            rise_cyc.push_back(cyc);
            if (exp_req.size() == 0) begin
               check("req_unexpected", exp_req.size(), 1);
            end else begin
               e = exp_req.pop_front();
               check("req_chan_trig", {rd_chan, rd_trig_type, rd_trig_num}, e);
            end
         end
         prev = rd_req;
      end
   end

   // Completion monitor.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (readout_done) begin
            done_seen++;
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
               check("done_unexpected", exp_done.size(), 1);
            end else begin
               e = exp_done.pop_front();
               check("done_mask_counts", {3'b000, timeout_mask, timeout_count, event_count}, e);
            end
         end
      end
   end

   initial begin
      int base, p0, r0, k;
      reset = 1'b1; enable = 1'b0; chan_en = 5'd0;
      repeat (3) @(negedge clk);
      check("rst_state", state, S_IDLE);
      check("rst_ctrl", {evt_fifo_rd, rd_req, readout_done, rd_chan}, 0);
      check("rst_counts", {timeout_mask, timeout_count, event_count}, 0);
      reset = 1'b0;
      @(negedge clk);

      // All five channels; chan_en/enable changed mid-event must not matter.
      enable = 1'b1; chan_en = 5'b11111; done_delay = 10;
      base = rise_cyc.size();
      for (int c = 0; c < 5; c++) exp_req.push_back(req_word(c, 32'h0A000123));
      exp_done.push_back(done_word(5'd0, 8'd0, 16'd1));
      fifo_q.push_back(32'h0A000123);
      k = 0;
      while (rd_pulses == 0 && k < 20) begin @(negedge clk); k++; end
      check("t1_fetch", rd_pulses, 1);
      chan_en = 5'b00001; enable = 1'b0;
      wait_done_count(1, 300);
      check("t1_req_count", rise_cnt, 5);
      if (rise_cyc.size() > base) check("t1_req_latency", rise_cyc[base] - fifo_rd_cyc, 1);
      check("t1_done_latency", done_cyc - last_done_in_cyc, 3);

      // Sparse channels, back-to-back entries.
      enable = 1'b1; chan_en = 5'b10100; p0 = rd_pulses;
      exp_req.push_back(req_word(2, 32'h05ABCDEF));
      exp_req.push_back(req_word(4, 32'h05ABCDEF));
      exp_req.push_back(req_word(2, 32'h1F000001));
      exp_req.push_back(req_word(4, 32'h1F000001));
      exp_done.push_back(done_word(5'd0, 8'd0, 16'd2));
      exp_done.push_back(done_word(5'd0, 8'd0, 16'd3));
      fifo_q.push_back(32'h05ABCDEF);
      fifo_q.push_back(32'h1F000001);
      wait_done_count(3, 400);
      check("t2_fifo_pops", rd_pulses - p0, 2);

      // Channel 1 never completes: 16 cycles in WAIT_DONE, then channel 2.
      chan_en = 5'b00110; dead_mask = 5'b00010;
      base = rise_cyc.size();
      exp_req.push_back(req_word(1, 32'h03000010));
      exp_req.push_back(req_word(2, 32'h03000010));
      exp_done.push_back(done_word(5'b00010, 8'd1, 16'd4));
      fifo_q.push_back(32'h03000010);
      wait_done_count(4, 300);
      if (rise_cyc.size() > base + 1) check("t3_timeout_gap", rise_cyc[base + 1] - rise_cyc[base], 18);
      dead_mask = 5'd0;
      exp_req.push_back(req_word(1, 32'h03000011));
      exp_req.push_back(req_word(2, 32'h03000011));
      exp_done.push_back(done_word(5'd0, 8'd1, 16'd5));
      fifo_q.push_back(32'h03000011);
      wait_done_count(5, 300);

      // rd_done lands exactly when the counter reaches 0: no timeout.
      chan_en = 5'b00011; done_delay = 16;
      exp_req.push_back(req_word(0, 32'h04000020));
      exp_req.push_back(req_word(1, 32'h04000020));
      exp_done.push_back(done_word(5'd0, 8'd1, 16'd6));
      fifo_q.push_back(32'h04000020);
      wait_done_count(6, 300);
      done_delay = 10;
      stray_req++;
      repeat (4) @(negedge clk);
      check("stray_done_state", state, S_IDLE);
      check("stray_done_events", event_count, 16'd6);
      check("stray_done_pulses", done_seen, 6);

      // Disabled fetch, then an event with no channels.
      enable = 1'b0; chan_en = 5'd0; p0 = rd_pulses; r0 = rise_cnt;
      fifo_q.push_back(32'h06000030);
      repeat (10) @(negedge clk);
      check("t5_no_pop", rd_pulses - p0, 0);
      check("t5_idle", state, S_IDLE);
      exp_done.push_back(done_word(5'd0, 8'd1, 16'd7));
      enable = 1'b1;
      wait_done_count(7, 100);
      check("t5_done_latency", done_cyc - fifo_rd_cyc, 2);
      check("t5_no_req", rise_cnt - r0, 0);

      // Asynchronous reset while waiting on a dead channel.
      chan_en = 5'b00001; dead_mask = 5'b00001;
      exp_req.push_back(req_word(0, 32'h07000040));
      fifo_q.push_back(32'h07000040);
      fifo_q.push_back(32'h07000041);
      k = 0;
      while (state != S_WAIT_DONE && k < 40) begin @(negedge clk); k++; end
      check("t6_reach_wait", state, S_WAIT_DONE);
      #3 reset = 1'b1;
      #1;
      check("t6_rst_state", state, S_IDLE);
      check("t6_rst_ctrl", {evt_fifo_rd, rd_req, readout_done, rd_chan}, 0);
      check("t6_rst_trig", {rd_trig_type, rd_trig_num}, 0);
      check("t6_rst_counts", {timeout_mask, timeout_count, event_count}, 0);
      repeat (2) @(negedge clk);
      check("t6_entry_kept", fifo_q.size(), 1);
      dead_mask = 5'd0;
      exp_req.push_back(req_word(0, 32'h07000041));
      exp_done.push_back(done_word(5'd0, 8'd0, 16'd1));
      reset = 1'b0;
      wait_done_count(8, 200);

      repeat (5) @(negedge clk);
      check("leftover_req", exp_req.size(), 0);
      check("leftover_done", exp_done.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
